// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Purpose  : SPI slave shift register, CPOL=1 (mode 2), MSB first. Exchanges
//            one DATA_WIDTH-bit word per frame with an external master. The
//            SPI pins are sampled in the clk domain. The host loads transmit
//            data with ld and collects received words on data_o, qualified
//            by a one-cycle rdy pulse.
// Ports    : clk     system clock, rising edge
//            rst     synchronous reset, active-high
//            sck     SPI clock from master, idles high
//            sdi     MOSI
//            sdo     MISO, always driven from int_sdo
//            ss      slave select, active-low
//            data_i  parallel transmit word
//            data_o  last complete received word
//            ld      load data_i into the shift register (frame boundary only)
//            rdy     one-cycle pulse marking a completed frame
// Options  : SPISLAVE_SYNC_EN - when defined, sck/sdi/ss each pass through a
//            2-flop synchronizer (all latencies +2 clk, sck phases >= 4 clk).
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  sdi,
    output logic                  sdo,
    input  logic                  ss,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ld,
    output logic                  rdy
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] int_sr;
    logic                  int_sdo;
    logic                  int_rdy;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  sck_q;

    logic                  sck_in;
    logic                  sdi_in;
    logic                  ss_in;

`ifdef SPISLAVE_SYNC_EN
    // Two-stage synchronizers for an asynchronous master. ss resets to the
    // deselected level so no spurious frame activity follows reset.
    logic [1:0] sck_sync;
    logic [1:0] sdi_sync;
    logic [1:0] ss_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync <= 2'b11;
            sdi_sync <= 2'b00;
            ss_sync  <= 2'b11;
        end else begin
            sck_sync <= {sck_sync[0], sck};
            sdi_sync <= {sdi_sync[0], sdi};
            ss_sync  <= {ss_sync[0], ss};
        end
    end

    assign sck_in = sck_sync[1];
    assign sdi_in = sdi_sync[1];
    assign ss_in  = ss_sync[1];
`else
    assign sck_in = sck;
    assign sdi_in = sdi;
    assign ss_in  = ss;
`endif

    logic                  sck_fall;
    logic                  sck_rise;
    logic [DATA_WIDTH-1:0] sr_shifted;

    assign sck_fall   = sck_q & ~sck_in & ~ss_in;
    assign sck_rise   = ~sck_q & sck_in & ~ss_in;
    assign sr_shifted = {int_sr[DATA_WIDTH-2:0], sdi_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            int_sr  <= '0;
            int_sdo <= 1'b0;
            int_rdy <= 1'b0;
            bit_cnt <= '0;
            sck_q   <= 1'b0;
            data_o  <= '0;
        end else begin
            sck_q   <= sck_in;
            int_rdy <= 1'b0;

            if (ss_in) begin
                // Deselected: abort any partial frame but keep int_sr and
                // int_sdo. A load is still accepted at a frame boundary so
                // the host can prepare the next word while deselected.
                bit_cnt <= '0;
                if (ld && (bit_cnt == '0)) begin
                    int_sr  <= data_i;
                    int_sdo <= data_i[DATA_WIDTH-1];
                end
            end else if (sck_fall) begin
                if (bit_cnt == CNT_LAST) begin
                    // Frame complete. A same-cycle load replaces the clear
                    // so back-to-back frames can carry fresh data.
                    data_o  <= sr_shifted;
                    int_rdy <= 1'b1;
                    bit_cnt <= '0;
                    if (ld) begin
                        int_sr  <= data_i;
                        int_sdo <= data_i[DATA_WIDTH-1];
                    end else begin
                        int_sr  <= '0;
                    end
                end else begin
                    // A falling edge at count 0 is the first bit of a frame;
                    // sampling it takes priority over a coincident load.
                    int_sr  <= sr_shifted;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end else if (ld && (bit_cnt == '0)) begin
                // Load beats a coincident rising edge so the new MSB is
                // what appears on sdo.
                int_sr  <= data_i;
                int_sdo <= data_i[DATA_WIDTH-1];
            end else if (sck_rise) begin
                int_sdo <= int_sr[DATA_WIDTH-1];
            end
        end
    end

    assign sdo = int_sdo;
    assign rdy = int_rdy;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Purpose  : Self-checking bench for spi_slave. A directed SPI mode-2 master
//            drives frames; each frame pushes its expected data_o word into
//            a scoreboard queue, and a monitor pops and compares on rdy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int W  = 8;
    localparam int PH = 4;   // clk cycles per sck phase

    logic         clk = 1'b0;
    logic         rst;
    logic         sck;
    logic         sdi;
    logic         sdo;
    logic         ss;
    logic [W-1:0] data_i;
    logic [W-1:0] data_o;
    logic         ld;
    logic         rdy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    spi_slave #(.DATA_WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .sck    (sck),
        .sdi    (sdi),
        .sdo    (sdo),
        .ss     (ss),
        .data_i (data_i),
        .data_o (data_o),
        .ld     (ld),
        .rdy    (rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: every rdy pulse must match the oldest queued word.
    always @(negedge clk) begin
        if (!rst && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdy_unexpected: got rdy with data_o 0x%0h, expected no rdy", data_o);
            end else begin
                chk("data_o_on_rdy", 32'(data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_load(input logic [W-1:0] val);
        data_i = val;
        ld     = 1'b1;
        clks(1);
        ld     = 1'b0;
    endtask

    // One full frame. tx is sent on MOSI, MISO is compared with exp_miso.
    // With ld_last set, ld/ld_val are driven around the final falling edge.
    task automatic frame(input string name, input logic [W-1:0] tx, input logic [W-1:0] exp_miso,
                         input bit ld_last, input logic [W-1:0] ld_val);
        logic [W-1:0] rx;
        rx = '0;
        exp_q.push_back(tx);
        ss = 1'b0;
        clks(PH);
        for (int i = W - 1; i >= 0; i--) begin
            sdi = tx[i];
            clks(PH);
            rx[i] = sdo;
            sck   = 1'b0;
            if (i == 0 && ld_last) begin
                data_i = ld_val;
                ld     = 1'b1;
            end
            clks(PH);
            ld  = 1'b0;
            sck = 1'b1;
        end
        clks(PH);
        chk(name, 32'(rx), 32'(exp_miso));
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst    = 1'b1;
        sck    = 1'b1;
        sdi    = 1'b0;
        ss     = 1'b1;
        data_i = '0;
        ld     = 1'b0;
        clks(4);
        rst = 1'b0;
        clks(4);

        chk("reset_sdo",    32'(sdo),        32'h0);
        chk("reset_data_o", 32'(data_o),     32'h00);
        chk("reset_rdy",    32'(rdy),        32'h0);
        chk("reset_int_sr", 32'(dut.int_sr), 32'h00);

        // Load 0x80, then exchange 0x80.
        do_load(8'h80);
        clks(3);
        chk("load_int_sr",  32'(dut.int_sr), 32'h80);
        chk("load_sdo_msb", 32'(sdo),        32'h1);
        frame("miso_0x80", 8'h80, 8'h80, 1'b0, 8'h00);
        chk("data_o_0x80", 32'(data_o), 32'h80);

        // No reload: shift register was cleared, so MISO is all zeros.
        frame("miso_noreload_a", 8'h01, 8'h00, 1'b0, 8'h00);
        chk("data_o_0x01", 32'(data_o), 32'h01);
        frame("miso_noreload_b", 8'h80, 8'h00, 1'b0, 8'h00);
        chk("data_o_0x80b", 32'(data_o), 32'h80);

        // All-zero exchange.
        do_load(8'h00);
        frame("miso_zero", 8'h00, 8'h00, 1'b0, 8'h00);
        chk("data_o_zero", 32'(data_o), 32'h00);

        // Abort after 4 bits of 0xFF.
        ss = 1'b1;
        clks(PH);
        do_load(8'hA5);
        ss = 1'b0;
        clks(PH);
        for (int i = 0; i < 4; i++) begin
            sdi = 1'b1;
            clks(PH);
            sck = 1'b0;
            clks(PH);
            sck = 1'b1;
        end
        clks(PH);
        ss = 1'b1;
        clks(2 * PH);
        chk("abort_data_o", 32'(data_o),     32'h00);
        chk("abort_int_sr", 32'(dut.int_sr), 32'h5F);

        // Mid-frame ld ignored is not exercised here; fresh load after abort.
        do_load(8'h3C);
        frame("miso_after_abort", 8'hC3, 8'h3C, 1'b0, 8'h00);
        chk("data_o_0xC3", 32'(data_o), 32'hC3);

        // Load coincident with frame completion.
        frame("miso_before_ldlast", 8'h96, 8'h00, 1'b1, 8'h5A);
        chk("data_o_0x96", 32'(data_o), 32'h96);
        frame("miso_ldlast", 8'h24, 8'h5A, 1'b0, 8'h00);
        chk("data_o_0x24", 32'(data_o), 32'h24);

        ss = 1'b1;
        clks(2 * PH);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
# spi_slave

SPI slave shift register (CPOL=1, MSB first) that exchanges one `DATA_WIDTH`-bit word per frame with an external master. It uses the system clock domain: `sck`, `sdi` and `ss` are sampled by `clk`. The host side loads transmit data with `ld` and collects received data on `data_o`, qualified by a one-cycle `rdy` pulse. It sits between the board-level SPI pins and the MIDI router control logic.

## Interface
- `DATA_WIDTH`, default 8: word length in bits (≥2).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `sck`  in  1  SPI clock from master; idles high.
- `sdi`  in  1  MOSI.
- `sdo`  out  1  MISO; driven from register `int_sdo`; never tristated.
- `ss`  in  1  slave select, active-low.
- `data_i`  in  `DATA_WIDTH`  parallel transmit word.
- `data_o`  out  `DATA_WIDTH`  last complete received word.
- `ld`  in  1  load `data_i` into the shift register.
- `rdy`  out  1  one-cycle pulse marking a completed frame.

## Operation
- Internal state:
  - `int_sr`, a `DATA_WIDTH`-bit shift register.
  - `int_sdo`, the output bit register.
  - `int_rdy`, which drives `rdy`.
  - A bit counter, 0..`DATA_WIDTH`-1.
  - `sck_q`, the previous sampled `sck`.
- Edge detect:
  - A falling edge is `sck_q`=1 and `sck`=0.
  - A rising edge is `sck_q`=0 and `sck`=1.
  - Edges count only while `ss`=0.
- Load: when `ld`=1 and the counter is 0:
  - `int_sr` ← `data_i`.
  - `int_sdo` ← `data_i[DATA_WIDTH-1]`.
  - `ld` while the counter is nonzero (mid-frame) is ignored.
- Falling edge: sample MOSI.
  - `int_sr` ← {`int_sr[DATA_WIDTH-2:0]`, `sdi`}.
  - The counter increments.
- Rising edge: drive MISO.
  - `int_sdo` ← `int_sr[DATA_WIDTH-1]`.
- Frame complete, on the falling edge that brings the count to `DATA_WIDTH`:
  - `data_o` ← the fully shifted word.
  - `rdy` = 1 for exactly one clk.
  - The counter returns to 0.
  - `int_sr` ← 0, so an unreloaded next frame transmits all zeros.
- `ld` in the same cycle as frame completion wins: `int_sr` ← `data_i` instead of 0, and `data_o`/`rdy` still update.
- `ss`=1 mid-frame aborts the frame:
  - The counter is cleared.
  - `data_o` is unchanged and no `rdy` pulse is issued.
  - `int_sr` keeps its partial contents.
- While `ss`=1: `int_sdo` holds its value, and no shifting occurs.
- Reset: `int_sr`, `int_sdo`/`sdo`, `data_o`, `rdy`, the counter and `sck_q` all go to 0.

## Timing
- The master changes `sdi` after a rising `sck` edge and samples `sdo` at the falling edge (SPI mode 2).
- First bit: the MSB is present on `sdo` immediately after `ld` (1 clk), before the first falling edge.
- Load latency: `int_sr` equals `data_i` on the clk edge after `ld`=1.
- Without the synchronizer, each `sck` high and low phase is ≥1 clk period (`sck` ≤ clk/2).
- `sdi` is stable at the clk edge where the falling `sck` is detected.
- `sdo` updates 1 clk after the detected rising edge.
- `rdy` asserts 1 clk after the last detected falling edge; `data_o` is valid in the same cycle and holds until the next completion or reset.
- Back-to-back frames are allowed: `ss` may stay low, and the counter wraps 0→`DATA_WIDTH`-1→0.

## Configuration
- `SPISLAVE_SYNC_EN` defined:
  - `sck`, `sdi` and `ss` each pass through a 2-flop synchronizer before edge detection and sampling, for asynchronous masters.
  - Every latency above grows by 2 clk.
  - `sck` phases must be ≥4 clk.
- `SPISLAVE_SYNC_EN` undefined: inputs are used directly (single `sck_q` stage), and the inputs must be synchronous to `clk`.

## Test plan
- Reset, then idle → `sdo`=0, `data_o`=0x00, `rdy`=0; `int_sr`=0x00.
- `ld` with `data_i`=0x80, then a frame sending 0x80 → `int_sr`=0x80 1 clk after `ld`; MISO reads 0x80; `data_o`=0x80; one `rdy` pulse.
- Frame sending 0x01 with no reload → MISO reads 0x00; `data_o`=0x01; a following frame sending 0x80 reads 0x00 and gives `data_o`=0x80.
- `ld` 0x00, frame sending 0x00 → MISO 0x00, `data_o`=0x00, `rdy` pulses once.
- `ld` 0xA5, then `ss` raised after 4 bits of 0xFF → no `rdy`, `data_o` unchanged; a new `ld` 0x3C plus a full frame reads 0x3C.
- `ld` asserted in the frame-completion cycle with `data_i`=0x5A → the next frame reads 0x5A (not 0x00); the previous frame's `data_o` and `rdy` are still correct.
